// File: rtl/rv32i_ctrl_decoder.sv
// rv32i_ctrl_decoder: main control decoder for the single-cycle RV32I core.
// Turns the opcode class, funct3 and funct7 bit 5 into datapath steering
// signals and an ALU operation select. All outputs are registered, so each
// decode appears one clock after its inputs are sampled.
//
// Optional build macro: RV32I_CTRL_ILLEGAL_DET_EN
//   undefined - any opcode outside the known set decodes as a store.
//   defined   - adds an `illegal` output; unknown opcodes raise it and
//               decode as a harmless no-op with every write enable low.

package rv32i_pkg;

  // Opcode classes recognised by the decoder (instruction bits [6:0]).
  typedef enum logic [6:0] {
    I_TYPE_LOAD = 7'd3,
    I_TYPE_ALU  = 7'd19,
    S_TYPE      = 7'd35,
    R_TYPE      = 7'd51,
    B_TYPE      = 7'd99
  } instr_type_t;

  // funct3 field (instruction bits [14:12]).
  typedef enum logic [2:0] {
    ADD_SUB_BEQ = 3'd0,
    SLL_F       = 3'd1,
    SLT_F       = 3'd2,
    SLTU_F      = 3'd3,
    XOR_F       = 3'd4,
    SRL_SRA_F   = 3'd5,
    OR_F        = 3'd6,
    AND_F       = 3'd7
  } func_code_t;

  // ALU operation select.
  typedef enum logic [3:0] {
    ADD_OP = 4'd0,
    SUB_OP = 4'd1,
    AND_OP = 4'd2,
    OR_OP  = 4'd3,
    XOR_OP = 4'd4,
    SLL_OP = 4'd5,
    SRL_OP = 4'd6,
    SRA_OP = 4'd7,
    BEQ_OP = 4'd8
  } alu_op_t;

  // Immediate formats selected by immsrc.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // How the ALU operation is chosen for a given opcode class.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_BRANCH,
    CLS_FUNCT
  } alu_class_t;

  // Full set of registered decoder outputs.
  typedef struct packed {
    logic [1:0] immsrc;
    logic       resultsrc;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       branch;
    alu_op_t    alu_ctrl;
    logic       illegal;
  } ctrl_t;

  // Value loaded on reset: nothing written, nothing branched, ALU adds.
  localparam ctrl_t CTRL_RESET = '{
    immsrc:    IMM_I,
    resultsrc: 1'b0,
    memwrite:  1'b0,
    alusrc:    1'b0,
    regwrite:  1'b0,
    branch:    1'b0,
    alu_ctrl:  ADD_OP,
    illegal:   1'b0
  };

endpackage : rv32i_pkg

module rv32i_ctrl_decoder
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  instr_type_t instr_type,
  input  func_code_t  func_code,
  input  logic        funct7b5,
  output logic        branch,
  output logic        resultsrc,
  output logic        memwrite,
  output logic        alusrc,
  output logic [1:0]  immsrc,
  output logic        regwrite,
  output alu_op_t     alu_ctrl
`ifdef RV32I_CTRL_ILLEGAL_DET_EN
  ,
  output logic        illegal
`endif
);

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  alu_class_t alu_class;
  logic       is_r_type;
  alu_op_t    alu_op;

  assign is_r_type = (instr_type == R_TYPE);

  // Main decode: steering signals and ALU class from the opcode alone.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    ctrl_d    = CTRL_RESET;
    alu_class = CLS_ADD;
    unique case (instr_type)
      R_TYPE: begin
        ctrl_d.regwrite = 1'b1;
        alu_class       = CLS_FUNCT;
      end
      I_TYPE_LOAD: begin
        ctrl_d.resultsrc = 1'b1;
        ctrl_d.alusrc    = 1'b1;
        ctrl_d.regwrite  = 1'b1;
        alu_class        = CLS_ADD;
      end
      I_TYPE_ALU: begin
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.regwrite = 1'b1;
        alu_class       = CLS_FUNCT;
      end
      B_TYPE: begin
        ctrl_d.immsrc = IMM_B;
        ctrl_d.branch = 1'b1;
        alu_class     = CLS_BRANCH;
      end
      S_TYPE: begin
        ctrl_d.immsrc   = IMM_S;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        alu_class       = CLS_ADD;
      end
      default: begin
`ifdef RV32I_CTRL_ILLEGAL_DET_EN
        // Unknown opcode: flag it and keep every write enable low.
        ctrl_d.illegal = 1'b1;
        alu_class      = CLS_ADD;
`else
        // Unknown opcode behaves exactly like a store.
        ctrl_d.immsrc   = IMM_S;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        alu_class       = CLS_ADD;
`endif
      end
    endcase
    ctrl_d.alu_ctrl = alu_op;
  end

  // ALU decode: pick the operation from the class, funct3 and funct7 bit 5.
  always_comb begin
    alu_op = ADD_OP;
    unique case (alu_class)
      CLS_BRANCH: alu_op = BEQ_OP;
      CLS_FUNCT: begin
        unique case (func_code)
          // Subtract only for R-type; ADDI has no funct7 and always adds.
          ADD_SUB_BEQ: alu_op = (is_r_type && funct7b5) ? SUB_OP : ADD_OP;
          SLL_F:       alu_op = SLL_OP;
          XOR_F:       alu_op = XOR_OP;
          // Shift-right arithmetic vs logical is bit 30 for both R and I.
          SRL_SRA_F:   alu_op = funct7b5 ? SRA_OP : SRL_OP;
          OR_F:        alu_op = OR_OP;
          AND_F:       alu_op = AND_OP;
          // SLT/SLTU encodings select the add operation.
          default:     alu_op = ADD_OP;
        endcase
      end
      default: alu_op = ADD_OP;
    endcase
  end

  // Output register with synchronous reset taking priority over decode.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its input from before the edge, independent of block order.
    if (rst) begin
      ctrl_q <= CTRL_RESET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign immsrc    = ctrl_q.immsrc;
  assign resultsrc = ctrl_q.resultsrc;
  assign memwrite  = ctrl_q.memwrite;
  assign alusrc    = ctrl_q.alusrc;
  assign regwrite  = ctrl_q.regwrite;
  assign branch    = ctrl_q.branch;
  assign alu_ctrl  = ctrl_q.alu_ctrl;

`ifdef RV32I_CTRL_ILLEGAL_DET_EN
  assign illegal = ctrl_q.illegal;
`else
  // The illegal flag is constant zero without detection; leave it unused.
  logic unused_illegal;
  assign unused_illegal = ctrl_q.illegal;
`endif

endmodule : rv32i_ctrl_decoder

// File: tb/tb_rv32i_ctrl_decoder.sv
// Testbench for rv32i_ctrl_decoder: directed scenarios plus a randomized
// back-to-back sequence compared against a table-driven reference model.
// Honors RV32I_CTRL_ILLEGAL_DET_EN the same way the design does.

module tb_rv32i_ctrl_decoder;
  import rv32i_pkg::*;

  logic        clk;
  logic        rst;
  instr_type_t instr_type;
  func_code_t  func_code;
  logic        funct7b5;
  logic        branch;
  logic        resultsrc;
  logic        memwrite;
  logic        alusrc;
  logic [1:0]  immsrc;
  logic        regwrite;
  alu_op_t     alu_ctrl;
  logic        illegal_obs;

  int total;
  int bad;

  rv32i_ctrl_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .instr_type(instr_type),
    .func_code (func_code),
    .funct7b5  (funct7b5),
    .branch    (branch),
    .resultsrc (resultsrc),
    .memwrite  (memwrite),
    .alusrc    (alusrc),
    .immsrc    (immsrc),
    .regwrite  (regwrite),
    .alu_ctrl  (alu_ctrl)
`ifdef RV32I_CTRL_ILLEGAL_DET_EN
    ,
    .illegal   (illegal_obs)
`endif
  );

`ifndef RV32I_CTRL_ILLEGAL_DET_EN
  assign illegal_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {immsrc, resultsrc, memwrite, alusrc, regwrite, branch, alu, illegal}
  function automatic logic [11:0] observed();
    return {immsrc, resultsrc, memwrite, alusrc, regwrite, branch, 4'(alu_ctrl), illegal_obs};
  endfunction

  // Reference model straight from the decode table, same packing as observed().
  function automatic logic [11:0] model(int op, int f3, bit b5);
    logic [5:0] flags;
    int         cls;  // 0 add, 1 branch, 2 funct
    bit         ill;
    alu_op_t    a;
    alu_op_t    ftab[8] = '{ADD_OP, SLL_OP, ADD_OP, ADD_OP, XOR_OP, SRL_OP, OR_OP, AND_OP};
    ill = 0;
    if (op == 51)      begin flags = 6'b00_0_0_0_1; cls = 2; end
    else if (op == 3)  begin flags = 6'b00_1_0_1_1; cls = 0; end
    else if (op == 19) begin flags = 6'b00_0_0_1_1; cls = 2; end
    else if (op == 99) begin flags = 6'b10_0_0_0_0; cls = 1; end
    else if (op == 35) begin flags = 6'b01_0_1_1_0; cls = 0; end
    else begin
`ifdef RV32I_CTRL_ILLEGAL_DET_EN
      flags = 6'b00_0_0_0_0; cls = 0; ill = 1;
`else
      flags = 6'b01_0_1_1_0; cls = 0;
`endif
    end
    if (cls == 1)      a = BEQ_OP;
    else if (cls == 0) a = ADD_OP;
    else begin
      a = ftab[f3];
      if (f3 == 0 && op == 51 && b5) a = SUB_OP;
      if (f3 == 5 && b5)              a = SRA_OP;
    end
    return {flags[5:4], flags[3], flags[2], flags[1], flags[0], op == 99 ? 1'b1 : 1'b0, 4'(a), ill};
  endfunction

  task automatic drive(int op, int f3, bit b5);
    instr_type = instr_type_t'(7'(op));
    func_code  = func_code_t'(3'(f3));
    funct7b5   = b5;
  endtask

  // Apply inputs, let one edge pass, sample 1 time unit after the edge.
  task automatic step(int op, int f3, bit b5);
    drive(op, f3, b5);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1;
    drive(51, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    obs = observed();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_rtype: got %h expected %h", obs, 12'h000);
    end
    // Store inputs held during reset must not leak through either.
    step(35, 2, 1'b1);
    obs = observed();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_store: got %h expected %h", obs, 12'h000);
    end
    drive(51, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (regwrite !== 1'b1 || alu_ctrl !== ADD_OP || memwrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got regwrite=%b alu=%0d memwrite=%b expected 1 %0d 0",
               regwrite, alu_ctrl, memwrite, ADD_OP);
    end
  endtask

  task automatic test_r_type();
    int      f3s[7] = '{0, 1, 4, 5, 5, 6, 7};
    bit      b5s[7] = '{1, 0, 0, 1, 0, 0, 0};
    alu_op_t exp[7] = '{SUB_OP, SLL_OP, XOR_OP, SRA_OP, SRL_OP, OR_OP, AND_OP};
    for (int i = 0; i < 7; i++) begin
      step(51, f3s[i], b5s[i]);
      total++;
      if (alu_ctrl !== exp[i] || regwrite !== 1'b1 || alusrc !== 1'b0 ||
          memwrite !== 1'b0 || branch !== 1'b0 || resultsrc !== 1'b0) begin
        bad++;
        $display("FAIL r_type f3=%0d b5=%0d: got alu=%0d rw=%b src=%b expected alu=%0d rw=1 src=0",
                 f3s[i], b5s[i], alu_ctrl, regwrite, alusrc, exp[i]);
      end
    end
  endtask

  task automatic test_i_alu();
    step(19, 0, 1'b1);
    total++;
    if (alu_ctrl !== ADD_OP || alusrc !== 1'b1 || immsrc !== 2'b00 || regwrite !== 1'b1) begin
      bad++;
      $display("FAIL addi_b5: got alu=%0d src=%b imm=%b rw=%b expected %0d 1 00 1",
               alu_ctrl, alusrc, immsrc, regwrite, ADD_OP);
    end
    step(19, 5, 1'b1);
    total++;
    if (alu_ctrl !== SRA_OP || alusrc !== 1'b1) begin
      bad++;
      $display("FAIL srai: got alu=%0d src=%b expected %0d 1", alu_ctrl, alusrc, SRA_OP);
    end
  endtask

  task automatic test_load_store();
    for (int f = 0; f < 8; f += 3) begin
      step(3, f, f[0]);
      total++;
      if (resultsrc !== 1'b1 || alusrc !== 1'b1 || regwrite !== 1'b1 ||
          memwrite !== 1'b0 || alu_ctrl !== ADD_OP) begin
        bad++;
        $display("FAIL load f3=%0d: got res=%b src=%b rw=%b mw=%b alu=%0d expected 1 1 1 0 %0d",
                 f, resultsrc, alusrc, regwrite, memwrite, alu_ctrl, ADD_OP);
      end
    end
    step(35, 5, 1'b1);
    total++;
    if (memwrite !== 1'b1 || immsrc !== 2'b01 || regwrite !== 1'b0 ||
        alusrc !== 1'b1 || alu_ctrl !== ADD_OP) begin
      bad++;
      $display("FAIL store: got mw=%b imm=%b rw=%b src=%b alu=%0d expected 1 01 0 1 %0d",
               memwrite, immsrc, regwrite, alusrc, alu_ctrl, ADD_OP);
    end
  endtask

  task automatic test_branch();
    step(99, 7, 1'b1);
    total++;
    if (branch !== 1'b1 || immsrc !== 2'b10 || alusrc !== 1'b0 ||
        regwrite !== 1'b0 || memwrite !== 1'b0 || alu_ctrl !== BEQ_OP) begin
      bad++;
      $display("FAIL branch: got br=%b imm=%b src=%b rw=%b mw=%b alu=%0d expected 1 10 0 0 0 %0d",
               branch, immsrc, alusrc, regwrite, memwrite, alu_ctrl, BEQ_OP);
    end
  endtask

  task automatic test_unknown_opcode();
    logic [11:0] obs;
    logic [11:0] exp;
    step(8'h7F, 0, 1'b1);
    obs = observed();
`ifdef RV32I_CTRL_ILLEGAL_DET_EN
    exp = {2'b00, 5'b00000, 4'(ADD_OP), 1'b1};
`else
    exp = {2'b01, 5'b01100, 4'(ADD_OP), 1'b0};
`endif
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL opcode_7f: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    int          ops[5] = '{3, 19, 35, 51, 99};
    int          op;
    int          f3;
    bit          b5;
    logic [11:0] obs;
    logic [11:0] exp;
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 5) == 0) op = int'($urandom_range(0, 127));
      else                           op = ops[$urandom_range(0, 4)];
      f3 = int'($urandom_range(0, 7));
      b5 = 1'($urandom_range(0, 1));
      step(op, f3, b5);
      obs = observed();
      exp = model(op, f3, b5);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL b2b[%0d] op=%0d f3=%0d b5=%0d: got %h expected %h", i, op, f3, b5, obs, exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(51, 0, 1'b0);
    test_reset();
    test_r_type();
    test_i_alu();
    test_load_store();
    test_branch();
    test_unknown_opcode();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rv32i_ctrl_decoder
